rst_seq_ctrl: RTL
=================

// Module: rst_seq_ctrl
// PURPOSE
//  Reset source/sequencer for the multi-clock system; sits upstream of the per-domain reset synchronizers.
//  Merges power-on, software and external reset requests into one stretched reset.
//  Releases the domain resets one at a time with a fixed stagger, then reports completion.
//  Outputs are active-low and glitch-free (registered) so each can drive a domain synchronizer directly.
// PARAMETERS
//  NUM_DOMAINS    2   number of sequenced reset outputs (>=1)
//  ASSERT_CYCLES  16  minimum cycles all outputs are held low per reset event (>=2)
//  STAGGER_CYCLES 4   cycles between release of domain k and domain k+1 (>=1)
//  HOLDOFF_CYCLES 8   cycles after the last release before DONE; new requests are latched, not serviced
//  CNT_WIDTH      8   counter width; must hold max(ASSERT,STAGGER,HOLDOFF)_CYCLES
// PORTS
//  CLK         in   1            system clock
//  RST         in   1            asynchronous, active-high reset (power-on reset)
//  REQ_SW      in   1            software reset request, 1-cycle pulse, sync to CLK
//  REQ_EXT     in   1            external reset request, level, pre-synchronised to CLK
//  RST_OUT_N   out  NUM_DOMAINS  per-domain reset, active-low; bit 0 released first
//  BUSY        out  1            high from request acceptance until DONE
//  DONE        out  1            1-cycle pulse: sequence complete
//  RST_CAUSE   out  2            cause of last reset: 00 POR, 01 SW, 10 EXT; 11 unused
// BEHAVIOUR
//  Reset (RST=1, async): state ASSERT, cnt=0, RST_OUT_N=all 0, BUSY=1, DONE=0, RST_CAUSE=00, pending=0.
//  All outputs are registered; each output changes on the same edge that the state changes.
//  States: IDLE, ASSERT, RELEASE, HOLDOFF.
//  IDLE: RST_OUT_N all 1, BUSY=0. REQ_SW or REQ_EXT sampled high -> ASSERT on next edge.
//    On that edge: RST_OUT_N all 0, BUSY=1, RST_CAUSE updated, cnt=0.
//  ASSERT: all outputs low; cnt increments.
//    Leave to RELEASE when cnt==ASSERT_CYCLES-1 and REQ_EXT==0.
//    While REQ_EXT==1, or on any REQ_SW, cnt restarts at 0 (reset extension).
//  RELEASE: entering edge sets RST_OUT_N[0]=1; RST_OUT_N[k] rises STAGGER_CYCLES after [k-1].
//    Once released, bits stay 1 until abort.
//    After the edge releasing bit NUM_DOMAINS-1 -> HOLDOFF. With NUM_DOMAINS=1, go straight to HOLDOFF.
//    Any request during RELEASE: abort; next edge all RST_OUT_N=0, ASSERT, cnt=0, cause updated.
//  HOLDOFF: outputs stay released for HOLDOFF_CYCLES cycles; requests set pending and store their cause.
//    At the end: DONE=1 for one cycle and BUSY=0 in that cycle. Next: IDLE, or ASSERT if pending (pending cleared).
//  Cause priority on simultaneous requests: EXT over SW. Cause holds until the next accepted request.
//  RST mid-sequence: immediate async return to reset values; POR sequence restarts on deassertion.
//  Latency (ASSERT=16, STAGGER=4, N=2): request at cycle t gives
//    RST_OUT_N=00 at t+1..t+16, [0]=1 at t+17, [1]=1 at t+21, DONE at t+29.
//  The counter never wraps: it saturates/clears per state. Compares are against CNT_WIDTH-truncated params;
//    an elaboration check fails if any *_CYCLES parameter exceeds 2**CNT_WIDTH-1.
// STRUCTURE
//  Shared package rst_seq_pkg: state enum (IDLE/ASSERT/RELEASE/HOLDOFF, 2-bit), cause codes
//    CAUSE_POR/SW/EXT, and a localparam helper for counter width.
//  One natural sub-module: rst_seq_cnt (CNT_WIDTH up-counter with clear, enable and terminal-match
//    output), reused for the assert, stagger and holdoff counts.
//  Domain index register ($clog2(NUM_DOMAINS) bits) selects the next bit to release.
// TESTING
//  POR: RST 1->0 at t0 -> RST_OUT_N=00 through t0+16, [0]=1 at t0+17, [1]=1 at t0+21,
//    DONE pulse at t0+29, RST_CAUSE=00.
//  SW request in IDLE: REQ_SW pulse at t -> same timing relative to t, RST_CAUSE=01, BUSY high t+1..t+28.
//  EXT held 40 cycles: RST_OUT_N=00 for 40+16 cycles, then normal release; REQ_SW pulse at same cycle
//    as EXT rise -> RST_CAUSE=10.
//  Abort: REQ_SW at t+19 (domain 0 released, 1 not yet) -> RST_OUT_N=00 at t+20, new full sequence from t+19.
//  Holdoff pending: REQ_SW at t+24 -> DONE at t+29, ASSERT re-entered at t+30, no IDLE cycle.
//  RST asserted mid-RELEASE: RST_OUT_N=00 and BUSY=1 without waiting for CLK; full POR sequence after release.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding, reset-cause codes,
// and the width helper for the domain index register.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_HOLDOFF = 2'd3
   } seq_state_t;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_EXT = 2'b10;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // External requests win over software ones when both arrive together.
   function automatic logic [1:0] cause_of(input logic req_ext);
      return req_ext ? CAUSE_EXT : CAUSE_SW;
   endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Saturating up-counter with synchronous clear and a terminal-match flag,
// shared by the assert, stagger and holdoff phases of the sequencer.
module rst_seq_cnt #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 clr,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] term,
   output logic                 hit
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] cnt_r;

   // Count register: clear wins, otherwise count up and stick at all-ones.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != '1)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign hit = (cnt_r == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset source/sequencer: merges POR, software and external requests into one stretched
// reset, then releases the active-low domain resets one by one and pulses DONE.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = 2,
   parameter int ASSERT_CYCLES  = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   REQ_SW,
   input  logic                   REQ_EXT,
   output logic [NUM_DOMAINS-1:0] RST_OUT_N,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [1:0]             RST_CAUSE
);

   localparam int IDX_W = idx_width(NUM_DOMAINS);
   localparam logic [CNT_WIDTH-1:0]   ASSERT_TERM  = CNT_WIDTH'(ASSERT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]   STAGGER_TERM = CNT_WIDTH'(STAGGER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]   HOLDOFF_TERM = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
   localparam logic [NUM_DOMAINS-1:0] DOM_ONE      = NUM_DOMAINS'(1);
   localparam logic [IDX_W-1:0]       IDX_ONE      = IDX_W'(1);
   localparam logic [IDX_W-1:0]       IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

   if ((NUM_DOMAINS < 1) || (ASSERT_CYCLES < 2) || (STAGGER_CYCLES < 1) || (HOLDOFF_CYCLES < 1) ||
       (ASSERT_CYCLES > (2**CNT_WIDTH) - 1) || (STAGGER_CYCLES > (2**CNT_WIDTH) - 1) ||
       (HOLDOFF_CYCLES > (2**CNT_WIDTH) - 1)) begin : g_param_err
      $error("rst_seq_ctrl: cycle parameter out of range for CNT_WIDTH");
   end

   seq_state_t             state_r;
   logic [NUM_DOMAINS-1:0] rst_out_r;
   logic                   busy_r;
   logic                   done_r;
   logic [1:0]             cause_r;
   logic                   pend_r;
   logic [1:0]             pend_cause_r;
   logic [IDX_W-1:0]       dom_idx_r;

   logic                 req_s;
   logic                 hit_s;
   logic                 cnt_clr_s;
   logic                 cnt_en_s;
   logic [CNT_WIDTH-1:0] term_s;

   // Counter control: every phase transition restarts the count from zero.
   always_comb begin
      req_s     = REQ_SW | REQ_EXT;
      cnt_en_s  = (state_r != ST_IDLE);
      term_s    = '0;
      cnt_clr_s = 1'b1;
      case (state_r)
         ST_IDLE: begin
            term_s    = '0;
            cnt_clr_s = 1'b1;
         end
         ST_ASSERT: begin
            term_s    = ASSERT_TERM;
            cnt_clr_s = req_s | hit_s;
         end
         ST_RELEASE: begin
            term_s    = STAGGER_TERM;
            cnt_clr_s = req_s | hit_s;
         end
         ST_HOLDOFF: begin
            term_s    = HOLDOFF_TERM;
            cnt_clr_s = hit_s | done_r;
         end
         default: begin
            term_s    = '0;
            cnt_clr_s = 1'b1;
         end
      endcase
   end

   rst_seq_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (cnt_clr_s),
      .en   (cnt_en_s),
      .term (term_s),
      .hit  (hit_s)
   );

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r      <= ST_ASSERT;
         rst_out_r    <= '0;
         busy_r       <= 1'b1;
         done_r       <= 1'b0;
         cause_r      <= CAUSE_POR;
         pend_r       <= 1'b0;
         pend_cause_r <= CAUSE_POR;
         dom_idx_r    <= '0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  state_r   <= ST_ASSERT;
                  rst_out_r <= '0;
                  busy_r    <= 1'b1;
                  cause_r   <= cause_of(REQ_EXT);
               end
            end
            ST_ASSERT: begin
               if (hit_s && !req_s) begin
                  rst_out_r <= DOM_ONE;
                  dom_idx_r <= IDX_ONE;
                  state_r   <= (NUM_DOMAINS == 1) ? ST_HOLDOFF : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (req_s) begin
                  state_r   <= ST_ASSERT;
                  rst_out_r <= '0;
                  cause_r   <= cause_of(REQ_EXT);
               end else if (hit_s) begin
                  // Released bits form a thermometer growing from bit 0.
                  rst_out_r <= (rst_out_r << 1) | DOM_ONE;
                  dom_idx_r <= dom_idx_r + IDX_ONE;
                  if (dom_idx_r == IDX_LAST) begin
                     state_r <= ST_HOLDOFF;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (done_r) begin
                  pend_r <= 1'b0;
                  if (req_s || pend_r) begin
                     state_r   <= ST_ASSERT;
                     rst_out_r <= '0;
                     busy_r    <= 1'b1;
                     cause_r   <= req_s ? cause_of(REQ_EXT) : pend_cause_r;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  if (req_s) begin
                     pend_r       <= 1'b1;
                     pend_cause_r <= cause_of(REQ_EXT);
                  end
                  if (hit_s) begin
                     done_r <= 1'b1;
                     busy_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r   <= ST_ASSERT;
               rst_out_r <= '0;
               busy_r    <= 1'b1;
            end
         endcase
      end
   end

   assign RST_OUT_N = rst_out_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;
   assign RST_CAUSE = cause_r;

endmodule
